// File: rtl/writeback_pkg.sv
// Shared types for the writeback arbiter: late-result FIFO entry and the zero register index.
package writeback_pkg;

    typedef struct packed {
        logic [4:0]  dest_reg;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_late_fifo.sv
// Synchronous FIFO of late results. Extra pointer bit separates full from empty.
// Exposes every slot plus a "still resident after this edge" mask for hazard compares.
module wb_late_fifo
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output wb_entry_t [DEPTH-1:0] peek_entry,
    output logic [DEPTH-1:0]      peek_keep
);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [AW:0]           wr_q, rd_q;
    logic                  do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign peek_entry = mem_q;

    // Occupied slots, minus the head when it leaves on this edge.
    always_comb begin
        logic [AW-1:0] off;
        peek_keep = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_q[AW-1:0];
            peek_keep[i] = ({1'b0, off} < count) && !(do_pop && (off == '0));
        end
    end

    // Pointer and storage update; push and pop may share an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= push_entry;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/stage_writeback_arbiter.sv
// WB stage: MEM->WB pipe register merged with late (mul/div) results through a FIFO.
// Pipe slot always wins the register-file port; the FIFO drains on idle cycles.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module stage_writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int LATE_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          nullify,
    input  logic                          in_valid,
    input  logic                          in_write_reg,
    input  logic [4:0]                    in_dest_reg,
    input  logic [31:0]                   in_dest_data,
    input  logic                          late_valid,
    output logic                          late_ready,
    input  logic [4:0]                    late_dest_reg,
    input  logic [31:0]                   late_data,
    output logic                          wb_write_reg,
    output logic [4:0]                    wb_dest_reg,
    output logic [31:0]                   wb_dest_data,
    input  logic [4:0]                    rs_addr,
    input  logic [4:0]                    rt_addr,
    output logic                          fwd_rs,
    output logic                          fwd_rt,
    output logic                          late_hazard,
    output logic [$clog2(LATE_DEPTH):0]   pending_count,
    output logic [31:0]                   retired_count
);

    logic      valid_q, valid_d;
    logic      wr_q, wr_d;
    wb_entry_t pipe_q, pipe_d;

    wb_entry_t                  head;
    wb_entry_t [LATE_DEPTH-1:0] peek_entry;
    logic [LATE_DEPTH-1:0]      peek_keep;
    logic                       full, empty, pipe_writes, pop;

    // Pipe register next state: nullify beats stall beats capture.
    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        pipe_d  = pipe_q;
        if (nullify) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
            pipe_d  = '0;
        end else if (!stall) begin
            valid_d = in_valid;
            wr_d    = in_write_reg;
            pipe_d  = '{dest_reg: in_dest_reg, data: in_dest_data};
        end
    end

    // Pipe register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            pipe_q  <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            pipe_q  <= pipe_d;
        end
    end

    assign pipe_writes = valid_q && wr_q && (pipe_q.dest_reg != REG_ZERO);
    assign pop         = !pipe_writes && !empty;
    assign late_ready  = !full;

    wb_late_fifo #(.DEPTH(LATE_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (late_valid),
        .push_entry ('{dest_reg: late_dest_reg, data: late_data}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (pending_count),
        .peek_entry (peek_entry),
        .peek_keep  (peek_keep)
    );

    // Register-file port: pipe write, else FIFO head (dest 0 drains silently).
    always_comb begin
        wb_write_reg = 1'b0;
        wb_dest_reg  = '0;
        wb_dest_data = '0;
        if (pipe_writes) begin
            wb_write_reg = 1'b1;
            wb_dest_reg  = pipe_q.dest_reg;
            wb_dest_data = pipe_q.data;
        end else if (pop) begin
            wb_write_reg = (head.dest_reg != REG_ZERO);
            wb_dest_reg  = head.dest_reg;
            wb_dest_data = head.data;
        end
    end

    assign fwd_rs = wb_write_reg && (wb_dest_reg == rs_addr) && (rs_addr != REG_ZERO);
    assign fwd_rt = wb_write_reg && (wb_dest_reg == rt_addr) && (rt_addr != REG_ZERO);

    // Hazard against late results that remain queued past this edge.
    always_comb begin
        late_hazard = 1'b0;
        for (int i = 0; i < LATE_DEPTH; i++) begin
            if (peek_keep[i] && (peek_entry[i].dest_reg != REG_ZERO) &&
                ((peek_entry[i].dest_reg == rs_addr) || (peek_entry[i].dest_reg == rt_addr)))
                late_hazard = 1'b1;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (valid_q && !stall) retired_d = retired_q + 32'd1;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired_count = retired_q;
`else
    assign retired_count = 32'd0;
`endif

endmodule
